friscv_regfile_sb: RTL and testbench

// Parametrised ISA register file with a per-register scoreboard (busy bits), for the pipelined core.

---
 rtl/friscv_regfile_sb.sv | 131 +++++++++++++
 tb/tb_friscv_regfile_sb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_regfile_sb.sv
// friscv_regfile_sb: ISA register file with per-register busy scoreboard
//
// Register file for the pipelined core. It has NB_RD combinational read ports
// and NB_WR byte-strobed write ports. Write port 0 has the highest priority.
// Decode reserves a destination register through a valid/ready handshake,
// and write-back retires that reservation with wr_clr.
//
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   srst           synchronous active-high reset, overrides all updates
//   rd_addr        NB_RD packed 5-bit read addresses
//   rd_val         NB_RD packed XLEN read data
//   rd_busy        per read port: addressed register has a pending write
//   rsv_valid      reserve-destination request
//   rsv_addr       register to reserve
//   rsv_ready      reservation accepted this cycle
//   wr_en          per write port enable
//   wr_addr        NB_WR packed 5-bit write addresses
//   wr_val         NB_WR packed XLEN write data
//   wr_strb        NB_WR packed XLEN/8 byte strobes
//   wr_clr         per write port: retire the reservation of wr_addr
//   busy_vec       scoreboard state (debug)
//   regs_flat      register contents, x0 at LSBs (debug)
module friscv_regfile_sb #(
    parameter int XLEN    = 32,
    parameter int NB_REGS = 32,
    parameter int NB_RD   = 6,
    parameter int NB_WR   = 3,
    parameter int BYPASS  = 1
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      srst,
    input  logic [NB_RD*5-1:0]        rd_addr,
    output logic [NB_RD*XLEN-1:0]     rd_val,
    output logic [NB_RD-1:0]          rd_busy,
    input  logic                      rsv_valid,
    input  logic [4:0]                rsv_addr,
    output logic                      rsv_ready,
    input  logic [NB_WR-1:0]          wr_en,
    input  logic [NB_WR*5-1:0]        wr_addr,
    input  logic [NB_WR*XLEN-1:0]     wr_val,
    input  logic [NB_WR*XLEN/8-1:0]   wr_strb,
    input  logic [NB_WR-1:0]          wr_clr,
    output logic [NB_REGS-1:0]        busy_vec,
    output logic [NB_REGS*XLEN-1:0]   regs_flat
);

    localparam int NB = XLEN / 8;

    logic [NB_REGS-1:0][XLEN-1:0] regs;
    logic [NB_REGS-1:0][XLEN-1:0] nxt;
    logic [NB_REGS-1:0]           busy;
    logic [NB_REGS-1:0]           clr;
    logic [NB_REGS-1:0]           set;
    logic [NB_REGS-1:0]           busy_nxt;

    // 32-entry views so any 5-bit address indexes safely; entries at or
    // above NB_REGS stay zero, which makes those reads return 0 / not busy.
    logic [31:0][XLEN-1:0] cur_ext;
    logic [31:0][XLEN-1:0] nxt_ext;
    logic [31:0]           busy_ext;
    logic [31:0]           clr_ext;

    // Next register contents and same-cycle clears. x0 is never touched.
    // Ports are scanned from the lowest priority upward, so port 0 is the
    // last writer of each byte and therefore wins.
    always_comb begin
        nxt = regs;
        clr = '0;
        for (int r = 1; r < NB_REGS; r++)
            for (int p = NB_WR - 1; p >= 0; p--)
                if (wr_en[p] && wr_addr[p*5+:5] == 5'(r)) begin
                    if (wr_clr[p])
                        clr[r] = 1'b1;
                    for (int b = 0; b < NB; b++)
                        if (wr_strb[p*NB+b])
                            nxt[r][b*8+:8] = wr_val[p*XLEN+b*8+:8];
                end
    end

    always_comb begin
        cur_ext = '0;
        nxt_ext = '0;
        busy_ext = '0;
        clr_ext = '0;
        cur_ext[NB_REGS-1:0] = regs;
        nxt_ext[NB_REGS-1:0] = nxt;
        busy_ext[NB_REGS-1:0] = busy;
        clr_ext[NB_REGS-1:0] = clr;
    end

    // x0 and out-of-range registers are never busy, so they are always accepted
    assign rsv_ready = rsv_valid & (~busy_ext[rsv_addr] | clr_ext[rsv_addr]);

    always_comb begin
        set = '0;
        for (int r = 1; r < NB_REGS; r++)
            set[r] = rsv_ready && rsv_addr == 5'(r);
    end

    // A reservation set overrides a same-cycle clear of the same register
    assign busy_nxt = (busy & ~clr) | set;

    genvar k;
    generate
        for (k = 0; k < NB_RD; k++) begin : g_rd
            assign rd_val[k*XLEN+:XLEN] = (BYPASS != 0) ? nxt_ext[rd_addr[k*5+:5]]
                                                        : cur_ext[rd_addr[k*5+:5]];
            assign rd_busy[k] = (BYPASS != 0) ? busy_ext[rd_addr[k*5+:5]] & ~clr_ext[rd_addr[k*5+:5]]
                                              : busy_ext[rd_addr[k*5+:5]];
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            regs <= '0;
            busy <= '0;
        end else if (srst) begin
            regs <= '0;
            busy <= '0;
        end else begin
            regs <= nxt;
            busy <= busy_nxt;
        end
    end

    assign busy_vec  = busy;
    assign regs_flat = regs;

endmodule

// File: tb/tb_friscv_regfile_sb.sv
// tb_friscv_regfile_sb: scoreboard bench for friscv_regfile_sb
module tb_friscv_regfile_sb;
  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         srst = 1'b0;
  logic [29:0]  rd_addr = '0;
  logic [191:0] rd_val1, rd_val2;
  logic [5:0]   rd_busy1, rd_busy2;
  logic         rsv_valid = 1'b0;
  logic [4:0]   rsv_addr = '0;
  logic         rsv_ready1, rsv_ready2;
  logic [2:0]   wr_en = '0;
  logic [14:0]  wr_addr = '0;
  logic [95:0]  wr_val = '0;
  logic [11:0]  wr_strb = '0;
  logic [2:0]   wr_clr = '0;
  logic [31:0]  busy_vec1;
  logic [15:0]  busy_vec2;
  logic [1023:0] regs_flat1;
  logic [511:0]  regs_flat2;
  friscv_regfile_sb #(.XLEN(32), .NB_REGS(32), .NB_RD(6), .NB_WR(3), .BYPASS(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .rd_addr(rd_addr), .rd_val(rd_val1), .rd_busy(rd_busy1),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_val(wr_val), .wr_strb(wr_strb), .wr_clr(wr_clr),
    .busy_vec(busy_vec1), .regs_flat(regs_flat1)
  );
  friscv_regfile_sb #(.XLEN(32), .NB_REGS(16), .NB_RD(6), .NB_WR(3), .BYPASS(0)) dut2 (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .rd_addr(rd_addr), .rd_val(rd_val2), .rd_busy(rd_busy2),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_val(wr_val), .wr_strb(wr_strb), .wr_clr(wr_clr),
    .busy_vec(busy_vec2), .regs_flat(regs_flat2)
  );
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;
  typedef struct {
    int          cyc;
    int          d;
    int          kind;
    int          i;
    logic [31:0] v;
    string       name;
  } exp_t;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  function automatic logic [31:0] obs(input int d, input int kind, input int i);
    logic [31:0] r;
    r = '0;
    if (d == 1) begin
      if (kind == 0) r = rd_val1[i*32+:32];
      else if (kind == 1) r = {31'b0, rd_busy1[i]};
      else if (kind == 2) r = {31'b0, rsv_ready1};
      else if (kind == 3) r = busy_vec1;
      else r = regs_flat1[i*32+:32];
    end else begin
      if (kind == 0) r = rd_val2[i*32+:32];
      else if (kind == 1) r = {31'b0, rd_busy2[i]};
      else if (kind == 2) r = {31'b0, rsv_ready2};
      else if (kind == 3) r = {16'b0, busy_vec2};
      else r = regs_flat2[i*32+:32];
    end
    return r;
  endfunction
  always @(negedge aclk) begin
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].cyc == cyc) begin
        logic [31:0] got;
        got = obs(sb[j].d, sb[j].kind, sb[j].i);
        n_vec++;
        if (got !== sb[j].v) begin
          n_err++;
          $display("FAIL %s (d%0d cyc %0d): got %h expected %h",
                   sb[j].name, sb[j].d, cyc, got, sb[j].v);
        end
        sb.delete(j);
      end
    end
  end
  task automatic ex(input int lag, input int d, input int kind, input int i,
                    input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc + lag;
    e.d = d;
    e.kind = kind;
    e.i = i;
    e.v = v;
    e.name = name;
    sb.push_back(e);
  endtask
  task automatic idle();
    wr_en = '0;
    wr_clr = '0;
    wr_strb = '0;
    rsv_valid = 1'b0;
    srst = 1'b0;
  endtask
  task automatic step();
    @(posedge aclk);
    #1;
    idle();
  endtask
  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] v,
                    input logic [3:0] s, input logic c);
    wr_en[p] = 1'b1;
    wr_addr[p*5+:5] = a;
    wr_val[p*32+:32] = v;
    wr_strb[p*4+:4] = s;
    wr_clr[p] = c;
  endtask
  task automatic rd(input int k, input logic [4:0] a);
    rd_addr[k*5+:5] = a;
  endtask
  task automatic rsv(input logic [4:0] a);
    rsv_valid = 1'b1;
    rsv_addr = a;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    for (int k = 0; k < 6; k++) rd(k, 5'(k + 1));
    #1;
    n_vec += 4;
    if (rd_val1 !== 192'h0) begin
      n_err++;
      $display("FAIL reset_rd_val_all: got %h expected 0", rd_val1);
    end
    if (rd_busy1 !== 6'h0) begin
      n_err++;
      $display("FAIL reset_rd_busy_all: got %h expected 0", rd_busy1);
    end
    if (busy_vec1 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_busy_vec1: got %h expected 0", busy_vec1);
    end
    if (busy_vec2 !== 16'h0) begin
      n_err++;
      $display("FAIL reset_busy_vec2: got %h expected 0", busy_vec2);
    end
    for (int k = 0; k < 6; k++) begin
      ex(0, 1, 0, k, 32'h0, "reset_rd_val");
      ex(0, 1, 1, k, 32'h0, "reset_rd_busy");
    end
    ex(0, 2, 0, 0, 32'h0, "reset_rd_val");
    ex(0, 1, 3, 0, 32'h0, "reset_busy_vec");
    ex(0, 2, 3, 0, 32'h0, "reset_busy_vec");
    step();
    rd(0, 5'd5);
    wr(0, 5'd5, 32'hAAAAAAAA, 4'hF, 1'b0);
    wr(1, 5'd5, 32'h55555555, 4'hF, 1'b0);
    ex(0, 1, 0, 0, 32'hAAAAAAAA, "prio_bypass");
    ex(0, 2, 0, 0, 32'h0, "prio_nobypass");
    ex(1, 1, 4, 5, 32'hAAAAAAAA, "prio_x5");
    ex(1, 2, 4, 5, 32'hAAAAAAAA, "prio_x5");
    step();
    wr(0, 5'd5, 32'hAAAAAAAA, 4'h3, 1'b0);
    wr(1, 5'd5, 32'h55555555, 4'hC, 1'b0);
    ex(0, 1, 0, 0, 32'h5555AAAA, "merge_bypass");
    ex(0, 2, 0, 0, 32'hAAAAAAAA, "merge_nobypass");
    ex(1, 1, 4, 5, 32'h5555AAAA, "merge_x5");
    ex(1, 2, 4, 5, 32'h5555AAAA, "merge_x5");
    step();
    rd(1, 5'd7);
    rsv(5'd7);
    ex(0, 1, 2, 0, 32'h1, "rsv_first_ready");
    ex(0, 2, 2, 0, 32'h1, "rsv_first_ready");
    ex(0, 1, 1, 1, 32'h0, "rsv_not_forwarded");
    ex(1, 1, 3, 0, 32'h00000080, "rsv_busy_vec");
    ex(1, 2, 3, 0, 32'h00000080, "rsv_busy_vec");
    step();
    rsv(5'd7);
    ex(0, 1, 2, 0, 32'h0, "rsv_second_stall");
    ex(0, 2, 2, 0, 32'h0, "rsv_second_stall");
    ex(0, 1, 1, 1, 32'h1, "rsv_rd_busy");
    ex(0, 2, 1, 1, 32'h1, "rsv_rd_busy");
    ex(1, 1, 3, 0, 32'h00000080, "stall_busy_vec");
    step();
    rsv(5'd7);
    wr(2, 5'd7, 32'h00000077, 4'hF, 1'b1);
    ex(0, 1, 2, 0, 32'h1, "clr_rsv_ready");
    ex(0, 2, 2, 0, 32'h1, "clr_rsv_ready");
    ex(0, 1, 1, 1, 32'h0, "clr_fwd_busy");
    ex(0, 2, 1, 1, 32'h1, "clr_nofwd_busy");
    ex(0, 1, 0, 1, 32'h00000077, "clr_fwd_val");
    ex(1, 1, 3, 0, 32'h00000080, "set_wins");
    ex(1, 2, 3, 0, 32'h00000080, "set_wins");
    ex(1, 1, 4, 7, 32'h00000077, "clr_x7");
    step();
    wr(0, 5'd7, 32'hFFFFFFFF, 4'h0, 1'b1);
    ex(0, 1, 1, 1, 32'h0, "strb0_fwd_busy");
    ex(0, 2, 1, 1, 32'h1, "strb0_nofwd_busy");
    ex(0, 1, 0, 1, 32'h00000077, "strb0_val");
    ex(1, 1, 3, 0, 32'h0, "strb0_busy_vec");
    ex(1, 2, 3, 0, 32'h0, "strb0_busy_vec");
    ex(1, 2, 4, 7, 32'h00000077, "strb0_x7");
    step();
    wr(0, 5'd3, 32'hFFFFFFFF, 4'hF, 1'b0);
    step();
    rd(2, 5'd3);
    wr(1, 5'd3, 32'h12345678, 4'h1, 1'b0);
    ex(0, 1, 0, 2, 32'hFFFFFF78, "byte_bypass");
    ex(0, 2, 0, 2, 32'hFFFFFFFF, "byte_nobypass");
    ex(1, 2, 0, 2, 32'hFFFFFF78, "byte_next");
    ex(1, 1, 4, 3, 32'hFFFFFF78, "byte_x3");
    step();
    rd(3, 5'd0);
    wr(0, 5'd0, 32'hDEADBEEF, 4'hF, 1'b1);
    rsv(5'd0);
    ex(0, 1, 0, 3, 32'h0, "x0_rd");
    ex(0, 2, 0, 3, 32'h0, "x0_rd");
    ex(0, 1, 2, 0, 32'h1, "x0_rsv_ready");
    ex(0, 2, 2, 0, 32'h1, "x0_rsv_ready");
    ex(1, 1, 3, 0, 32'h0, "x0_busy_vec");
    ex(1, 1, 4, 0, 32'h0, "x0_reg");
    step();
    rd(4, 5'd20);
    wr(0, 5'd20, 32'hCAFEF00D, 4'hF, 1'b0);
    rsv(5'd20);
    ex(0, 2, 0, 4, 32'h0, "oor_rd");
    ex(0, 2, 1, 4, 32'h0, "oor_busy");
    ex(0, 2, 2, 0, 32'h1, "oor_rsv_ready");
    ex(0, 1, 0, 4, 32'hCAFEF00D, "x20_bypass");
    ex(1, 2, 0, 4, 32'h0, "oor_rd_next");
    ex(1, 2, 3, 0, 32'h0, "oor_busy_vec");
    ex(1, 1, 3, 0, 32'h00100000, "x20_busy_vec");
    ex(1, 1, 4, 20, 32'hCAFEF00D, "x20_reg");
    step();
    srst = 1'b1;
    wr(0, 5'd9, 32'h99999999, 4'hF, 1'b0);
    rsv(5'd9);
    ex(1, 1, 3, 0, 32'h0, "srst_busy_vec");
    ex(1, 2, 3, 0, 32'h0, "srst_busy_vec");
    ex(1, 1, 4, 5, 32'h0, "srst_x5");
    ex(1, 1, 4, 9, 32'h0, "srst_x9");
    ex(1, 1, 4, 20, 32'h0, "srst_x20");
    ex(1, 2, 4, 3, 32'h0, "srst_x3");
    step();
    rd(0, 5'd5);
    wr(0, 5'd5, 32'h00001234, 4'hF, 1'b0);
    rsv(5'd6);
    ex(1, 1, 4, 5, 32'h00001234, "pre_arst_x5");
    ex(1, 2, 3, 0, 32'h00000040, "pre_arst_busy");
    step();
    step();
    #1;
    aresetn = 1'b0;
    #1;
    n_vec += 4;
    if (regs_flat1 !== 1024'h0) begin
      n_err++;
      $display("FAIL arst_regs1: expected all registers 0 immediately");
    end
    if (regs_flat2 !== 512'h0) begin
      n_err++;
      $display("FAIL arst_regs2: expected all registers 0 immediately");
    end
    if (busy_vec1 !== 32'h0) begin
      n_err++;
      $display("FAIL arst_busy1: got %h expected 0", busy_vec1);
    end
    if (busy_vec2 !== 16'h0) begin
      n_err++;
      $display("FAIL arst_busy2: got %h expected 0", busy_vec2);
    end
    ex(0, 1, 4, 5, 32'h0, "arst_x5");
    ex(0, 2, 4, 5, 32'h0, "arst_x5");
    ex(0, 1, 3, 0, 32'h0, "arst_busy_vec");
    ex(0, 2, 3, 0, 32'h0, "arst_busy_vec");
    ex(0, 2, 0, 0, 32'h0, "arst_rd_val");
    step();
    aresetn = 1'b1;
    repeat (3) step();
    while (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s (d%0d): never checked, expected %h", sb[0].name, sb[0].d, sb[0].v);
      sb.pop_front();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
